// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM types and arbiter state encodings
package cpu_types_pkg;

  // Machine word used on every RAM and requester data path
  typedef logic [31:0] word_t;

  // RAM handshake state as reported by the single-port RAM
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter lock state: idle, or locked to the instruction/data side
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arbstate_t;

  // Which requester currently drives the RAM in this cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

  // Width of the fairness streak counter (saturates at all-ones)
  localparam int unsigned DSTREAK_W = 4;

endpackage

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - instruction/data arbiter in front of a single-port RAM
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned IFAIR = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam logic [DSTREAK_W-1:0] IFAIR_W  = DSTREAK_W'(IFAIR);
  localparam logic [DSTREAK_W-1:0] SAT_MAX  = '1;

  arbstate_t             state_q, state_d;
  logic [DSTREAK_W-1:0]  dstreak_q, dstreak_d;
  logic                  dwr_q, dwr_d;      // locked data transaction is a write
  word_t                 addr_q, addr_d;    // address shadow, held when nobody drives
  word_t                 store_q, store_d;  // write-data shadow

  logic   d_req;
  logic   starve;
  logic   access;
  grant_t gnt;

  assign d_req  = dREN | dWEN;
  assign starve = iREN && (dstreak_q >= IFAIR_W);
  assign access = (ramstate == ACCESS);

  // Pick the side that drives the RAM: arbitrate in IDLE, keep the lock otherwise
  always_comb begin
    gnt = GNT_NONE;
    case (state_q)
      IDLE: begin
        if (d_req && !starve) begin
          gnt = GNT_D;
        end else if (iREN) begin
          gnt = GNT_I;
        end
      end
      IBUSY: begin
        if (iREN) begin
          gnt = GNT_I;
        end
      end
      DBUSY: begin
        // A read/write flip is a new transaction, so it aborts the lock
        if (d_req && (dWEN == dwr_q)) begin
          gnt = GNT_D;
        end
      end
      default: gnt = GNT_NONE;
    endcase
  end

  // RAM drive, completion reporting, next state and fairness bookkeeping
  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    dwr_d     = dwr_q;
    addr_d    = addr_q;
    store_d   = store_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = addr_q;
    ramstore  = store_q;
    iwait     = iREN;
    dwait     = d_req;
    iload     = '0;
    dload     = '0;

    case (gnt)
      GNT_I: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        addr_d  = iaddr;
        if (access) begin
          iwait     = 1'b0;
          iload     = ramload;
          dstreak_d = '0;
          state_d   = IDLE;
        end else begin
          state_d   = IBUSY;
        end
      end
      GNT_D: begin
        // Write wins over read so the RAM never sees both enables
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        addr_d   = daddr;
        store_d  = dstore;
        dwr_d    = dWEN;
        if (access) begin
          dwait   = 1'b0;
          dload   = ramload;
          state_d = IDLE;
          if (iREN) begin
            dstreak_d = (dstreak_q == SAT_MAX) ? dstreak_q : dstreak_q + 1'b1;
          end else begin
            dstreak_d = '0;
          end
        end else begin
          state_d = DBUSY;
        end
      end
      default: begin
        // Nothing granted or the locked side withdrew: drop enables, back to IDLE
        state_d = IDLE;
      end
    endcase

    // In reset the RAM is quiet and no completion leaks out, even on ACCESS
    if (!nRST) begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = iREN;
      dwait    = d_req;
      iload    = '0;
      dload    = '0;
    end
  end

  // State, fairness counter and shadow registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      dwr_q     <= 1'b0;
      addr_q    <= '0;
      store_q   <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      dwr_q     <= dwr_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
    end
  end

endmodule
